// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a one-entry output slot.
// Owns the 16-bit PC and fetches words from instruction memory over req/ack.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   branch_valid_i      branch unit outputs meaningful this cycle
//   branch_en_i         branch taken
//   dest_addr_i         branch target, low 16 bits used
//   imem_req_o          fetch request, held until imem_ack_i
//   imem_addr_o         fetch word address
//   imem_ack_i          response valid (may arrive with first req cycle)
//   imem_rdata_i        instruction data, valid with ack
//   insn_valid_o        output slot holds an instruction
//   insn_o, insn_pc_o   slot instruction and its address
//   stall_i             decode not accepting the slot
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned INSN_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              branch_valid_i,
    input  logic              branch_en_i,
    input  logic [31:0]       dest_addr_i,
    output logic              imem_req_o,
    output logic [15:0]       imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INSN_W-1:0] imem_rdata_i,
    output logic              insn_valid_o,
    output logic [INSN_W-1:0] insn_o,
    output logic [15:0]       insn_pc_o,
    input  logic              stall_i
);

    logic              r_run;
    logic [15:0]       r_pc;
    logic              r_pending;
    logic [15:0]       r_req_addr;
    logic              r_drop;
    logic              r_valid;
    logic [INSN_W-1:0] r_insn;
    logic [15:0]       r_insn_pc;

    logic              w_redirect;
    logic              w_req;
    logic [15:0]       w_addr;
    logic              w_complete;
    logic              w_accept;
    logic              w_unused;

    assign w_unused   = ^dest_addr_i[31:16];
    assign w_redirect = branch_valid_i & branch_en_i;

    // Only request when the response is guaranteed a free slot.
    assign w_req      = r_run & (r_pending | ~r_valid | ~stall_i);
    assign w_addr     = r_pending ? r_req_addr : r_pc;
    assign w_complete = w_req & imem_ack_i;

    // Responses to requests issued before a redirect are discarded.
    assign w_accept   = w_complete & ~r_drop & ~w_redirect;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_run      <= 1'b0;
            r_pc       <= RESET_PC;
            r_pending  <= 1'b0;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_valid    <= 1'b0;
            r_insn     <= '0;
            r_insn_pc  <= '0;
        end else begin
            r_run <= 1'b1;

            // Latch the address so it stays stable until ack.
            if (w_complete) begin
                r_pending <= 1'b0;
            end else if (w_req && !r_pending) begin
                r_pending  <= 1'b1;
                r_req_addr <= r_pc;
            end

            // An outstanding request cannot be withdrawn, so mark it stale.
            if (w_complete) begin
                r_drop <= 1'b0;
            end else if (w_redirect && w_req) begin
                r_drop <= 1'b1;
            end

            if (w_redirect) begin
                r_pc <= dest_addr_i[15:0];
            end else if (w_accept) begin
                r_pc <= w_addr + 16'd1;
            end

            if (w_redirect) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_insn    <= imem_rdata_i;
                r_insn_pc <= w_addr;
            end else if (r_valid && !stall_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = w_addr;
    assign insn_valid_o = r_valid;
    assign insn_o       = r_insn;
    assign insn_pc_o    = r_insn_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Memory model with programmable ack delay; queues of expected fetches.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        bv;
    logic        ben;
    logic [31:0] dest;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] insn;
    logic [15:0] insn_pc;
    logic        stall;

    logic [3:0]  delay;
    logic [3:0]  wcnt;
    logic        force_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_req[$];
    logic [15:0] exp_out[$];

    fetch_unit #(
        .RESET_PC (16'h0010),
        .INSN_W   (32)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .branch_valid_i (bv),
        .branch_en_i    (ben),
        .dest_addr_i    (dest),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_ack_i     (ack),
        .imem_rdata_i   (rdata),
        .insn_valid_o   (valid),
        .insn_o         (insn),
        .insn_pc_o      (insn_pc),
        .stall_i        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    assign ack   = force_ack | (req && (wcnt >= delay));
    assign rdata = mem(addr);

    always @(posedge clk) begin
        wcnt <= (req && !ack) ? wcnt + 4'd1 : 4'd0;
    end

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Completed requests and consumed slot entries, checked in order.
    always @(negedge clk) begin
        if (rst_n && req && ack) begin
            if (exp_req.size() == 0)
                chk("req_unexp", 48'(exp_req.size()), 48'd1);
            else
                chk("req_addr", 48'(addr), 48'(exp_req.pop_front()));
        end
        if (rst_n && valid && !stall) begin
            if (exp_out.size() == 0) begin
                chk("out_unexp", 48'(exp_out.size()), 48'd1);
            end else begin
                logic [15:0] e;
                e = exp_out.pop_front();
                chk("out_pc", 48'(insn_pc), 48'(e));
                chk("out_data", 48'(insn), 48'(mem(e)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stall     = 1'b0;
        bv        = 1'b0;
        ben       = 1'b0;
        force_ack = 1'b0;
        step();
        chk("rst_valid", 48'(valid), 48'd0);
        chk("rst_insn", 48'(insn), 48'd0);
        chk("rst_pc", 48'(insn_pc), 48'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_req", 48'(req), 48'd0);
    endtask

    task automatic sb_done(input string tag);
        step();
        chk({tag, "_q_req"}, 48'(exp_req.size()), 48'd0);
        chk({tag, "_q_out"}, 48'(exp_out.size()), 48'd0);
        exp_req.delete();
        exp_out.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        bv        = 1'b0;
        ben       = 1'b0;
        dest      = '0;
        delay     = 4'd0;
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait streaming from RESET_PC.
        do_reset();
        for (int i = 0; i < 5; i++) exp_req.push_back(16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++) exp_out.push_back(16'h0010 + 16'(i));
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t1_addr", {31'd0, req, addr}, {31'd0, 1'b1, 16'h000F + 16'(i)});
            if (i >= 2)
                chk("t1_slot", {31'd0, valid, insn_pc}, {31'd0, 1'b1, 16'h000E + 16'(i)});
            else
                chk("t1_valid", 48'(valid), 48'd0);
        end
        step();
        stall = 1'b1;
        sb_done("t1");

        // Stall holds the slot and suppresses requests.
        do_reset();
        exp_req.push_back(16'h0010);
        exp_req.push_back(16'h0011);
        exp_req.push_back(16'h0012);
        exp_out.push_back(16'h0010);
        exp_out.push_back(16'h0011);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            stall = 1'b1;
            #1;
            chk("t2_req", 48'(req), 48'd0);
            chk("t2_slot", {31'd0, valid, insn_pc}, {31'd0, 1'b1, 16'h0011});
            chk("t2_insn", 48'(insn), 48'(mem(16'h0011)));
        end
        step();
        stall = 1'b0;
        #1;
        chk("t2_next", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0012});
        step();
        stall = 1'b1;
        chk("t2_slot2", 48'(insn_pc), 48'h0012);
        sb_done("t2");

        // Redirect while a slow request is pending.
        delay = 4'd3;
        do_reset();
        exp_req.push_back(16'h0010);
        exp_req.push_back(16'h0040);
        step();
        chk("t3_r1", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0010});
        step();
        bv   = 1'b1;
        ben  = 1'b1;
        dest = 32'hABCD_0040;
        chk("t3_r2", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0010});
        for (int c = 3; c <= 8; c++) begin
            step();
            bv  = 1'b0;
            ben = 1'b0;
            chk("t3_addr", {31'd0, req, addr},
                {31'd0, 1'b1, (c <= 4) ? 16'h0010 : 16'h0040});
            chk("t3_valid", 48'(valid), 48'd0);
        end
        step();
        stall = 1'b1;
        chk("t3_slot", {31'd0, valid, insn_pc}, {31'd0, 1'b1, 16'h0040});
        chk("t3_insn", 48'(insn), 48'(mem(16'h0040)));
        sb_done("t3");

        // Redirect in the same cycle as the ack for 0x0005.
        delay = 4'd0;
        do_reset();
        bv   = 1'b1;
        ben  = 1'b1;
        dest = 32'h0000_0005;
        exp_req.push_back(16'h0005);
        exp_req.push_back(16'h0200);
        step();
        dest = 32'h0000_0200;
        chk("t4_addr5", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0005});
        step();
        bv  = 1'b0;
        ben = 1'b0;
        chk("t4_valid", 48'(valid), 48'd0);
        chk("t4_tgt", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0200});
        step();
        stall = 1'b1;
        chk("t4_slot", {31'd0, valid, insn_pc}, {31'd0, 1'b1, 16'h0200});
        sb_done("t4");

        // PC wrap after redirect to 0xFFFF.
        do_reset();
        bv   = 1'b1;
        ben  = 1'b1;
        dest = 32'h0000_FFFF;
        exp_req.push_back(16'hFFFF);
        exp_req.push_back(16'h0000);
        exp_req.push_back(16'h0001);
        exp_out.push_back(16'hFFFF);
        exp_out.push_back(16'h0000);
        step();
        bv  = 1'b0;
        ben = 1'b0;
        chk("t5_a0", 48'(addr), 48'hFFFF);
        step();
        chk("t5_a1", 48'(addr), 48'h0000);
        step();
        chk("t5_a2", 48'(addr), 48'h0001);
        step();
        stall = 1'b1;
        chk("t5_slot", 48'(insn_pc), 48'h0001);
        sb_done("t5");

        // branch_en without branch_valid has no effect.
        do_reset();
        ben  = 1'b1;
        dest = 32'h0000_0999;
        exp_req.push_back(16'h0010);
        exp_req.push_back(16'h0011);
        exp_req.push_back(16'h0012);
        exp_out.push_back(16'h0010);
        exp_out.push_back(16'h0011);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_addr", 48'(addr), 48'h0010 + 48'(i));
        end
        step();
        stall = 1'b1;
        ben   = 1'b0;
        chk("t6_slot", 48'(insn_pc), 48'h0012);
        sb_done("t6");

        // Reset during a pending request; late ack ignored.
        delay = 4'd3;
        do_reset();
        step();
        chk("t7_pend", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0010});
        step();
        rst_n = 1'b0;
        step();
        chk("t7_valid", 48'(valid), 48'd0);
        chk("t7_insn", 48'(insn), 48'd0);
        chk("t7_pc", 48'(insn_pc), 48'd0);
        chk("t7_req", 48'(req), 48'd0);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        delay     = 4'd0;
        #1;
        chk("t7_req0", 48'(req), 48'd0);
        exp_req.push_back(16'h0010);
        step();
        force_ack = 1'b0;
        #1;
        chk("t7_late", 48'(valid), 48'd0);
        chk("t7_refetch", {31'd0, req, addr}, {31'd0, 1'b1, 16'h0010});
        step();
        stall = 1'b1;
        chk("t7_slot", {31'd0, valid, insn_pc}, {31'd0, 1'b1, 16'h0010});
        sb_done("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
